// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with rename (busy/tag) table and NRD read ports
module reg_rename_file #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int ROB_BIT = 4,
  parameter int NRD     = 2,
  localparam int RIDX   = $clog2(NREG)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   commit_en,
  input  logic [RIDX-1:0]        commit_rd,
  input  logic [XLEN-1:0]        commit_val,
  input  logic [ROB_BIT-1:0]     commit_tag,
  input  logic                   rename_en,
  input  logic [RIDX-1:0]        rename_rd,
  input  logic [ROB_BIT-1:0]     rename_tag,
  input  logic [NRD*RIDX-1:0]    rd_idx,
  output logic [NRD*XLEN-1:0]    rd_val,
  output logic [NRD-1:0]         rd_busy,
  output logic [NRD*ROB_BIT-1:0] rd_tag,
  output logic [NRD*ROB_BIT-1:0] rob_qtag,
  input  logic [NRD-1:0]         rob_qready,
  input  logic [NRD*XLEN-1:0]    rob_qval
);

  logic [XLEN-1:0]    val_q [NREG];
  logic [XLEN-1:0]    val_d [NREG];
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_d;
  logic [ROB_BIT-1:0] tag_q [NREG];
  logic [ROB_BIT-1:0] tag_d [NREG];

  // Next-state of the register file and rename table; x0 (index 0) is never touched.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_en && commit_rd == RIDX'(i)) begin
          // The retired value always lands, even while a flush discards renames.
          val_d[i] = commit_val;
          // Only the youngest producer may clear the rename; a same-cycle rename keeps it busy.
          if (!flush_in && tag_q[i] == commit_tag &&
              !(rename_en && rename_rd == RIDX'(i))) begin
            busy_d[i] = 1'b0;
            tag_d[i]  = '0;
          end
        end
        if (flush_in) begin
          busy_d[i] = 1'b0;
          tag_d[i]  = '0;
        end else if (rename_en && rename_rd == RIDX'(i)) begin
          busy_d[i] = 1'b1;
          tag_d[i]  = rename_tag;
        end
      end
    end
  end

  // State registers with synchronous reset; hold is folded into the _d logic.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [RIDX-1:0]    r;
    logic [XLEN-1:0]    v;
    logic               b;
    logic [ROB_BIT-1:0] t;
    logic [XLEN-1:0]    qv;

    assign r  = rd_idx[k*RIDX +: RIDX];
    assign qv = rob_qval[k*XLEN +: XLEN];

    // Operand lookup: same-cycle rename, then pending rename (with commit bypass), then file value.
    always_comb begin
      v = '0;
      b = 1'b0;
      t = '0;
      if (r != '0) begin
        if (rename_en && rename_rd == r) begin
          // A freshly allocated tag cannot be retiring this cycle, so ask the ROB.
          t = rename_tag;
          v = qv;
          b = !rob_qready[k];
        end else if (busy_q[r]) begin
          t = tag_q[r];
          if (commit_en && commit_tag == tag_q[r]) begin
            v = commit_val;
            b = 1'b0;
          end else begin
            v = qv;
            b = !rob_qready[k];
          end
        end else begin
          v = val_q[r];
        end
      end
    end

    assign rd_val[k*XLEN +: XLEN]       = v;
    assign rd_busy[k]                   = b;
    assign rd_tag[k*ROB_BIT +: ROB_BIT]   = t;
    assign rob_qtag[k*ROB_BIT +: ROB_BIT] = t;
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - self-checking bench for reg_rename_file
module tb_reg_rename_file;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RB   = 4;
  localparam int NRD  = 2;
  localparam int RIDX = 5;

  logic                 clk_in = 1'b0;
  logic                 rst_in, rdy_in, flush_in;
  logic                 commit_en, rename_en;
  logic [RIDX-1:0]      commit_rd, rename_rd;
  logic [XLEN-1:0]      commit_val;
  logic [RB-1:0]        commit_tag, rename_tag;
  logic [NRD*RIDX-1:0]  rd_idx;
  logic [NRD*XLEN-1:0]  rd_val;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*RB-1:0]    rd_tag;
  logic [NRD*RB-1:0]    rob_qtag;
  logic [NRD-1:0]       rob_qready;
  logic [NRD*XLEN-1:0]  rob_qval;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: what each architectural register holds and who will produce it
  logic [XLEN-1:0] m_val [NREG];
  bit              m_busy [NREG];
  int              m_tag [NREG];

  reg_rename_file #(.XLEN(XLEN), .NREG(NREG), .ROB_BIT(RB), .NRD(NRD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_tag(commit_tag), .rename_en(rename_en), .rename_rd(rename_rd),
    .rename_tag(rename_tag), .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy),
    .rd_tag(rd_tag), .rob_qtag(rob_qtag), .rob_qready(rob_qready), .rob_qval(rob_qval)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle();
    rst_in = 0; rdy_in = 1; flush_in = 0;
    commit_en = 0; commit_rd = 0; commit_val = 0; commit_tag = 0;
    rename_en = 0; rename_rd = 0; rename_tag = 0;
    rd_idx = 0; rob_qready = 0; rob_qval = 0;
  endtask

  task automatic model_clock();
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else if (rdy_in) begin
      int c = int'(commit_rd);
      int n = int'(rename_rd);
      if (commit_en && c != 0) begin
        m_val[c] = commit_val;
        if (!flush_in && m_tag[c] == int'(commit_tag) && !(rename_en && n == c)) begin
          m_busy[c] = 0; m_tag[c] = 0;
        end
      end
      if (flush_in) begin
        for (int i = 0; i < NREG; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      end else if (rename_en && n != 0) begin
        m_busy[n] = 1; m_tag[n] = int'(rename_tag);
      end
    end
  endtask

  task automatic model_read(input int k, output logic [XLEN-1:0] v, output logic b,
                            output logic [RB-1:0] t);
    int r = int'(rd_idx[k*RIDX +: RIDX]);
    v = 0; b = 0; t = 0;
    if (r == 0) return;
    if (rename_en && int'(rename_rd) == r) begin
      t = rename_tag; v = rob_qval[k*XLEN +: XLEN]; b = !rob_qready[k];
    end else if (m_busy[r]) begin
      t = RB'(m_tag[r]);
      if (commit_en && int'(commit_tag) == m_tag[r]) begin v = commit_val; b = 0; end
      else begin v = rob_qval[k*XLEN +: XLEN]; b = !rob_qready[k]; end
    end else begin
      v = m_val[r];
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst_in = 1; step(); idle();
    rd_idx = {5'd5, 5'd5}; #1;
    for (int k = 0; k < NRD; k++) begin
      n_cmp++; if (rd_val[k*XLEN +: XLEN] !== 32'h0) begin n_err++; $display("FAIL reset_val p%0d got %h want 0", k, rd_val[k*XLEN +: XLEN]); end
      n_cmp++; if (rd_busy[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy p%0d got %b want 0", k, rd_busy[k]); end
      n_cmp++; if (rd_tag[k*RB +: RB] !== 4'd0) begin n_err++; $display("FAIL reset_tag p%0d got %0d want 0", k, rd_tag[k*RB +: RB]); end
    end
  endtask

  task automatic test_rename_rob();
    idle(); rename_en = 1; rename_rd = 3; rename_tag = 2; step(); idle();
    rd_idx = {5'd3, 5'd3}; rob_qready = 2'b00; #1;
    for (int k = 0; k < NRD; k++) begin
      n_cmp++; if (rd_busy[k] !== 1'b1) begin n_err++; $display("FAIL ren_busy p%0d got %b want 1", k, rd_busy[k]); end
      n_cmp++; if (rd_tag[k*RB +: RB] !== 4'd2) begin n_err++; $display("FAIL ren_tag p%0d got %0d want 2", k, rd_tag[k*RB +: RB]); end
      n_cmp++; if (rob_qtag[k*RB +: RB] !== 4'd2) begin n_err++; $display("FAIL ren_qtag p%0d got %0d want 2", k, rob_qtag[k*RB +: RB]); end
    end
    rob_qready = 2'b11; rob_qval = {32'hAB, 32'hAB}; #1;
    for (int k = 0; k < NRD; k++) begin
      n_cmp++; if (rd_busy[k] !== 1'b0) begin n_err++; $display("FAIL rob_busy p%0d got %b want 0", k, rd_busy[k]); end
      n_cmp++; if (rd_val[k*XLEN +: XLEN] !== 32'hAB) begin n_err++; $display("FAIL rob_val p%0d got %h want ab", k, rd_val[k*XLEN +: XLEN]); end
    end
  endtask

  task automatic test_commit_bypass();
    idle(); commit_en = 1; commit_rd = 3; commit_tag = 2; commit_val = 32'h55;
    rd_idx = {5'd3, 5'd3}; #1;
    n_cmp++; if (rd_val[31:0] !== 32'h55) begin n_err++; $display("FAIL byp_val got %h want 55", rd_val[31:0]); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL byp_busy got %b want 0", rd_busy[0]); end
    step(); idle(); rd_idx = {5'd3, 5'd3}; #1;
    n_cmp++; if (rd_val[63:32] !== 32'h55) begin n_err++; $display("FAIL cmt_val got %h want 55", rd_val[63:32]); end
    n_cmp++; if (rd_busy[1] !== 1'b0 || rd_tag[7:4] !== 4'd0) begin n_err++; $display("FAIL cmt_clear got busy %b tag %0d want 0 0", rd_busy[1], rd_tag[7:4]); end
  endtask

  task automatic test_rename_commit_same();
    idle(); rename_en = 1; rename_rd = 3; rename_tag = 2; step();
    idle(); rename_en = 1; rename_rd = 3; rename_tag = 7;
    commit_en = 1; commit_rd = 3; commit_tag = 2; commit_val = 32'h66; step();
    idle(); rd_idx = {5'd3, 5'd3}; #1;
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL rc_busy got %b want 1", rd_busy[0]); end
    n_cmp++; if (rd_tag[3:0] !== 4'd7) begin n_err++; $display("FAIL rc_tag got %0d want 7", rd_tag[3:0]); end
  endtask

  task automatic test_flush();
    idle(); flush_in = 1; commit_en = 1; commit_rd = 4; commit_tag = 9; commit_val = 32'h99;
    rename_en = 1; rename_rd = 6; rename_tag = 5; step();
    idle(); rd_idx = {5'd6, 5'd4}; #1;
    n_cmp++; if (rd_val[31:0] !== 32'h99 || rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL fl_x4 got val %h busy %b want 99 0", rd_val[31:0], rd_busy[0]); end
    n_cmp++; if (rd_busy[1] !== 1'b0 || rd_tag[7:4] !== 4'd0 || rd_val[63:32] !== 32'h0) begin n_err++; $display("FAIL fl_x6 got busy %b tag %0d val %h want 0 0 0", rd_busy[1], rd_tag[7:4], rd_val[63:32]); end
    rd_idx = {5'd3, 5'd3}; #1;
    n_cmp++; if (rd_val[31:0] !== 32'h66 || rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL fl_x3 got val %h busy %b want 66 0", rd_val[31:0], rd_busy[0]); end
  endtask

  task automatic test_hold_x0();
    idle(); rename_en = 1; rename_rd = 8; rename_tag = 1; step();
    idle(); rdy_in = 0; flush_in = 1; commit_en = 1; commit_rd = 4; commit_val = 32'h11;
    rename_en = 1; rename_rd = 4; rename_tag = 3; step();
    idle(); rd_idx = {5'd8, 5'd4}; #1;
    n_cmp++; if (rd_val[31:0] !== 32'h99 || rd_busy[0] !== 1'b0 || rd_tag[3:0] !== 4'd0) begin n_err++; $display("FAIL hold_x4 got val %h busy %b tag %0d want 99 0 0", rd_val[31:0], rd_busy[0], rd_tag[3:0]); end
    n_cmp++; if (rd_busy[1] !== 1'b1 || rd_tag[7:4] !== 4'd1) begin n_err++; $display("FAIL hold_x8 got busy %b tag %0d want 1 1", rd_busy[1], rd_tag[7:4]); end
    idle(); commit_en = 1; commit_rd = 0; commit_val = 32'hFF; rename_en = 1; rename_rd = 0; rename_tag = 4;
    rd_idx = 0; #1;
    n_cmp++; if (rd_val[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || rd_tag[3:0] !== 4'd0) begin n_err++; $display("FAIL x0_comb got val %h busy %b tag %0d want 0 0 0", rd_val[31:0], rd_busy[0], rd_tag[3:0]); end
    step(); idle(); rd_idx = 0; #1;
    n_cmp++; if (rd_val[63:32] !== 32'h0 || rd_busy[1] !== 1'b0 || rd_tag[7:4] !== 4'd0) begin n_err++; $display("FAIL x0_seq got val %h busy %b tag %0d want 0 0 0", rd_val[63:32], rd_busy[1], rd_tag[7:4]); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ev;
    logic            eb;
    logic [RB-1:0]   et;
    for (int n = 0; n < 400; n++) begin
      rst_in     = ($urandom_range(0, 99) == 0);
      rdy_in     = ($urandom_range(0, 9) != 0);
      flush_in   = ($urandom_range(0, 19) == 0);
      commit_en  = $urandom_range(0, 1);
      commit_rd  = RIDX'($urandom_range(0, 7));
      commit_tag = RB'($urandom);
      commit_val = $urandom;
      rename_en  = $urandom_range(0, 1);
      rename_rd  = RIDX'($urandom_range(0, 7));
      rename_tag = RB'($urandom);
      for (int k = 0; k < NRD; k++) rd_idx[k*RIDX +: RIDX] = RIDX'($urandom_range(0, 7));
      rob_qready = NRD'($urandom);
      rob_qval   = {$urandom, $urandom};
      #1;
      for (int k = 0; k < NRD; k++) begin
        model_read(k, ev, eb, et);
        n_cmp++;
        if (rd_val[k*XLEN +: XLEN] !== ev || rd_busy[k] !== eb || rd_tag[k*RB +: RB] !== et ||
            rob_qtag[k*RB +: RB] !== et) begin
          n_err++;
          $display("FAIL rand it%0d p%0d got val %h busy %b tag %0d qtag %0d want %h %b %0d",
                   n, k, rd_val[k*XLEN +: XLEN], rd_busy[k], rd_tag[k*RB +: RB],
                   rob_qtag[k*RB +: RB], ev, eb, et);
        end
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    idle();
    @(negedge clk_in);
    test_reset();
    test_rename_rob();
    test_commit_bypass();
    test_rename_commit_same();
    test_flush();
    test_hold_x0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
